// File: rtl/brew_timer.sv
// Brew countdown timer. Drives a NUM_LEDS-pixel GRB progress bar from a 1 Hz tick strobe.
// The strip fills as the brew runs and blinks white once the brew is done.
module brew_timer #(
  parameter int NUM_LEDS  = 48,
  parameter int DUR_W     = 12,
  parameter int BRIGHT    = 255,
  parameter int DONE_HOLD = 60
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    tick,
  input  logic                    sw_start,
  input  logic                    sw_stop,
  input  logic                    sw_pause,
  input  logic [DUR_W-1:0]        brew_secs,
  output logic [NUM_LEDS*24-1:0]  framebuf,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_DONE} state_t;

  localparam int               HOLD_W = (DONE_HOLD < 2) ? 1 : $clog2(DONE_HOLD + 1);
  localparam logic [DUR_W-1:0] LEDS_D = DUR_W'(NUM_LEDS);
  localparam logic [7:0]       BR     = 8'(BRIGHT);

  state_t                  state_q, state_d;
  logic [DUR_W-1:0]        dur_q, dur_d;
  logic [DUR_W-1:0]        elapsed_q, elapsed_d;
  logic [DUR_W-1:0]        acc_q, acc_d;
  logic [DUR_W-1:0]        lit_q, lit_d;
  logic [HOLD_W-1:0]       hold_q, hold_d;
  logic                    phase_q, phase_d;
  logic                    done_q, done_d;
  logic [NUM_LEDS*24-1:0]  fb_q, fb_d;
  logic [DUR_W:0]          sum;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= S_IDLE;
      dur_q     <= '0;
      elapsed_q <= '0;
      acc_q     <= '0;
      lit_q     <= '0;
      hold_q    <= '0;
      phase_q   <= 1'b0;
      done_q    <= 1'b0;
      fb_q      <= '0;
    end else begin
      state_q   <= state_d;
      dur_q     <= dur_d;
      elapsed_q <= elapsed_d;
      acc_q     <= acc_d;
      lit_q     <= lit_d;
      hold_q    <= hold_d;
      phase_q   <= phase_d;
      done_q    <= done_d;
      fb_q      <= fb_d;
    end
  end

  // Events are mutually exclusive per cycle: stop > start > pause > tick.
  always_comb begin
    state_d   = state_q;
    dur_d     = dur_q;
    elapsed_d = elapsed_q;
    acc_d     = acc_q;
    lit_d     = lit_q;
    hold_d    = hold_q;
    phase_d   = phase_q;
    done_d    = 1'b0;
    sum       = (DUR_W+1)'(acc_q) + (DUR_W+1)'(NUM_LEDS);
    if (sw_stop) begin
      state_d   = S_IDLE;
      dur_d     = '0;
      elapsed_d = '0;
      acc_d     = '0;
      lit_d     = '0;
      hold_d    = '0;
      phase_d   = 1'b0;
    end else if (sw_start) begin
      state_d   = S_RUN;
      dur_d     = (brew_secs < LEDS_D) ? LEDS_D : brew_secs;
      elapsed_d = '0;
      acc_d     = '0;
      lit_d     = '0;
      hold_d    = '0;
      phase_d   = 1'b0;
    end else if (sw_pause) begin
      if (state_q == S_RUN)         state_d = S_PAUSED;
      else if (state_q == S_PAUSED) state_d = S_RUN;
    end else if (tick) begin
      case (state_q)
        S_RUN: begin
          elapsed_d = elapsed_q + DUR_W'(1);
          // Bresenham step: lit tracks floor(elapsed*NUM_LEDS/dur) without a divider.
          if (sum >= {1'b0, dur_q}) begin
            acc_d = DUR_W'(sum - {1'b0, dur_q});
            lit_d = lit_q + DUR_W'(1);
          end else begin
            acc_d = DUR_W'(sum);
          end
          if ((elapsed_q + DUR_W'(1)) == dur_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            phase_d = 1'b1;
            hold_d  = '0;
          end
        end
        S_DONE: begin
          phase_d = ~phase_q;
          hold_d  = hold_q + HOLD_W'(1);
          if (DONE_HOLD != 0 && (32'(hold_q) + 32'd1) == 32'(DONE_HOLD))
            state_d = S_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy = (state_q == S_RUN) || (state_q == S_PAUSED);
    fb_d = '0;
    case (state_q)
      S_RUN, S_PAUSED: begin
        for (int i = 0; i < NUM_LEDS; i++) begin
          if (DUR_W'(i) < lit_q)
            fb_d[24*i +: 8] = BR;
          else if (DUR_W'(i) == lit_q) begin
            if (state_q == S_RUN) fb_d[24*i+16 +: 8] = BR;
            else                  fb_d[24*i+8  +: 8] = BR;
          end
        end
      end
      S_DONE: begin
        if (phase_q) begin
          for (int i = 0; i < NUM_LEDS*3; i++) fb_d[8*i +: 8] = BR;
        end
      end
      default: ;
    endcase
  end

  assign framebuf = fb_q;
  assign done     = done_q;

endmodule

// File: tb/tb_brew_timer.sv
// Directed vector bench for brew_timer with an 8-pixel strip and a 4-tick done blink.
module tb_brew_timer;

  localparam int NL  = 8;
  localparam int FBW = NL * 24;

  localparam int K_OFF   = 0;
  localparam int K_RUN   = 1;
  localparam int K_PAUSE = 2;
  localparam int K_WHITE = 3;

  logic           clk = 1'b0;
  logic           nrst = 1'b0;
  logic           tick = 1'b0;
  logic           sw_start = 1'b0;
  logic           sw_stop = 1'b0;
  logic           sw_pause = 1'b0;
  logic [11:0]    brew_secs = '0;
  logic [FBW-1:0] framebuf;
  logic           busy;
  logic           done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic st, sp, pa, tk;
    int   secs;
    logic exp_busy, exp_done;
    int   kind, lit;
  } vec_t;

  vec_t vecs[$];

  brew_timer #(.NUM_LEDS(NL), .DUR_W(12), .BRIGHT(255), .DONE_HOLD(4)) dut (
    .clk(clk), .nrst(nrst), .tick(tick), .sw_start(sw_start), .sw_stop(sw_stop),
    .sw_pause(sw_pause), .brew_secs(brew_secs), .framebuf(framebuf),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [FBW-1:0] exp_fb(input int kind, input int lit);
    logic [FBW-1:0] f;
    f = '0;
    for (int i = 0; i < NL; i++) begin
      if (kind == K_WHITE) f[24*i +: 24] = 24'hFFFFFF;
      else if (kind == K_RUN || kind == K_PAUSE) begin
        if (i < lit) f[24*i +: 8] = 8'hFF;
        else if (i == lit) begin
          if (kind == K_RUN) f[24*i+16 +: 8] = 8'hFF;
          else               f[24*i+8  +: 8] = 8'hFF;
        end
      end
    end
    return f;
  endfunction

  task automatic chk(input string nm, input logic [FBW-1:0] act, input logic [FBW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic st, input logic sp, input logic pa, input logic tk,
                     input int secs, input logic b, input logic d, input int kind, input int lit);
    vec_t v;
    v.st = st; v.sp = sp; v.pa = pa; v.tk = tk; v.secs = secs;
    v.exp_busy = b; v.exp_done = d; v.kind = kind; v.lit = lit;
    vecs.push_back(v);
  endtask

  task automatic run_tick(input int lit);
    add(0, 0, 0, 1, 0, 1, 0, K_RUN, lit);
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    sw_start = v.st; sw_stop = v.sp; sw_pause = v.pa; tick = v.tk;
    brew_secs = 12'(v.secs);
    @(negedge clk);
    sw_start = 0; sw_stop = 0; sw_pause = 0; tick = 0;
    chk($sformatf("v%0d_done", idx), FBW'(done), FBW'(v.exp_done));
    @(negedge clk);
    chk($sformatf("v%0d_done_len", idx), FBW'(done), '0);
    chk($sformatf("v%0d_busy", idx), FBW'(busy), FBW'(v.exp_busy));
    chk($sformatf("v%0d_fb", idx), framebuf, exp_fb(v.kind, v.lit));
  endtask

  initial begin
    int l1[19] = '{0,0,1,1,2,2,2,3,3,4,4,4,5,5,6,6,6,7,7};
    int l3a[6] = '{0,0,1,1,2,2};
    int l3b[13] = '{2,3,3,4,4,4,5,5,6,6,6,7,7};

    // 20 s brew, then 4-tick blink and auto-return to idle
    add(1, 0, 0, 0, 20, 1, 0, K_RUN, 0);
    foreach (l1[k]) run_tick(l1[k]);
    add(0, 0, 0, 1, 0, 0, 1, K_WHITE, 0);
    add(0, 0, 0, 1, 0, 0, 0, K_OFF, 0);
    add(0, 0, 0, 1, 0, 0, 0, K_WHITE, 0);
    add(0, 0, 0, 1, 0, 0, 0, K_OFF, 0);
    add(0, 0, 0, 1, 0, 0, 0, K_OFF, 0);
    add(0, 0, 0, 1, 0, 0, 0, K_OFF, 0);
    // Short duration clamped to strip length
    add(1, 0, 0, 0, 3, 1, 0, K_RUN, 0);
    for (int k = 1; k <= 7; k++) run_tick(k);
    add(0, 0, 0, 1, 0, 0, 1, K_WHITE, 0);
    add(0, 1, 0, 0, 0, 0, 0, K_OFF, 0);
    // Pause for 5 ticks mid-brew, then resume
    add(1, 0, 0, 0, 20, 1, 0, K_RUN, 0);
    foreach (l3a[k]) run_tick(l3a[k]);
    add(0, 0, 1, 0, 0, 1, 0, K_PAUSE, 2);
    for (int k = 0; k < 5; k++) add(0, 0, 0, 1, 0, 1, 0, K_PAUSE, 2);
    add(0, 0, 1, 0, 0, 1, 0, K_RUN, 2);
    foreach (l3b[k]) run_tick(l3b[k]);
    add(0, 0, 0, 1, 0, 0, 1, K_WHITE, 0);
    add(0, 1, 0, 0, 0, 0, 0, K_OFF, 0);
    // Simultaneous events
    add(1, 0, 0, 0, 20, 1, 0, K_RUN, 0);
    run_tick(0); run_tick(0); run_tick(1);
    add(1, 1, 0, 0, 20, 0, 0, K_OFF, 0);
    add(0, 0, 1, 0, 0, 0, 0, K_OFF, 0);
    add(0, 0, 0, 1, 0, 0, 0, K_OFF, 0);
    add(1, 0, 0, 0, 16, 1, 0, K_RUN, 0);
    run_tick(0); run_tick(1);
    add(0, 0, 1, 1, 0, 1, 0, K_PAUSE, 1);
    add(0, 0, 1, 0, 0, 1, 0, K_RUN, 1);
    run_tick(1);
    add(1, 0, 0, 1, 16, 1, 0, K_RUN, 0);
    run_tick(0); run_tick(1);
    add(0, 1, 0, 1, 0, 0, 0, K_OFF, 0);

    #2;
    chk("reset_fb", framebuf, '0);
    chk("reset_busy", FBW'(busy), '0);
    chk("reset_done", FBW'(done), '0);
    @(negedge clk);
    nrst = 1'b1;

    foreach (vecs[i]) apply(vecs[i], i);

    // Async reset while done is high in DONE
    apply('{st:1, sp:0, pa:0, tk:0, secs:3, exp_busy:1, exp_done:0, kind:K_RUN, lit:0}, 1000);
    for (int k = 1; k <= 7; k++)
      apply('{st:0, sp:0, pa:0, tk:1, secs:0, exp_busy:1, exp_done:0, kind:K_RUN, lit:k}, 1000 + k);
    @(negedge clk);
    tick = 1'b1;
    @(posedge clk);
    #2;
    tick = 1'b0;
    chk("rst_pre_done", FBW'(done), FBW'(1));
    chk("rst_pre_fb", framebuf, exp_fb(K_RUN, 7));
    nrst = 1'b0;
    #1;
    chk("rst_async_fb", framebuf, '0);
    chk("rst_async_busy", FBW'(busy), '0);
    chk("rst_async_done", FBW'(done), '0);
    @(negedge clk);
    nrst = 1'b1;
    for (int k = 0; k < 3; k++)
      apply('{st:0, sp:0, pa:0, tk:1, secs:0, exp_busy:0, exp_done:0, kind:K_OFF, lit:0}, 2000 + k);
    apply('{st:1, sp:0, pa:0, tk:0, secs:20, exp_busy:1, exp_done:0, kind:K_RUN, lit:0}, 2010);
    apply('{st:0, sp:0, pa:0, tk:1, secs:0, exp_busy:1, exp_done:0, kind:K_RUN, lit:0}, 2011);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
